// File: rtl/arch_pkg.sv
// Shared definitions for the arbiter family: mode encodings, default width,
// and the index-width helper used to size source-select buses.
package arch_pkg;

    localparam logic MODE_RR    = 1'b0;
    localparam logic MODE_FIXED = 1'b1;

    localparam int DATA_WIDTH = 32;

    // A one-source arbiter still needs a 1-bit index bus.
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_grant.sv
// Combinational grant logic: picks one requester, starting the search at base
// (round-robin, wrapping) or at index 0 (fixed priority).
module rr_grant
    import arch_pkg::*;
#(
    parameter  int NUM_SRC = 5,
    localparam int SEL_W   = clog2_min1(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [SEL_W-1:0]   base,
    input  logic               mode,
    output logic [NUM_SRC-1:0] grant,
    output logic [SEL_W-1:0]   grant_idx
);

    logic found;

    // NOTE: every output gets a default before the search loop, otherwise
    // paths that never match would infer latches.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            int idx;
            idx = (mode == MODE_FIXED) ? k : int'(base) + k;
            // base is always below NUM_SRC, so one subtraction wraps the search
            if (idx >= NUM_SRC) begin
                idx = idx - NUM_SRC;
            end
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = SEL_W'(idx);
            end
        end
    end

endmodule

// File: rtl/rr_arb_mux.sv
// N-source arbitrating multiplexer with valid/ready handshakes and a one-deep
// registered output stage; round-robin or fixed priority chosen at runtime.
module rr_arb_mux
    import arch_pkg::*;
#(
    parameter  int WIDTH   = DATA_WIDTH,
    parameter  int NUM_SRC = 5,
    localparam int SEL_W   = clog2_min1(NUM_SRC)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       mode,
    input  logic [NUM_SRC-1:0]         src_valid,
    input  logic [NUM_SRC*WIDTH-1:0]   src_data,
    output logic [NUM_SRC-1:0]         src_ready,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_data,
    output logic [SEL_W-1:0]           out_sel,
    input  logic                       out_ready
);

    logic [SEL_W-1:0]   ptr;
    logic [NUM_SRC-1:0] grant;
    logic [SEL_W-1:0]   grant_idx;
    logic               load;
    logic               xfer;
    logic [WIDTH-1:0]   win_data;

    rr_grant #(
        .NUM_SRC (NUM_SRC)
    ) u_grant (
        .req       (src_valid),
        .base      (ptr),
        .mode      (mode),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // The stage refills whenever it is empty or being drained this cycle.
    assign load      = !out_valid || out_ready;
    assign src_ready = grant & {NUM_SRC{load}};
    assign xfer      = |src_ready;

    // One-hot AND-OR mux keeps the data path free of a wide index decoder.
    always_comb begin
        win_data = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            win_data = win_data | (src_data[i*WIDTH +: WIDTH] & {WIDTH{grant[i]}});
        end
    end

    // NOTE: registers use non-blocking assignments so all state updates
    // see the same pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            ptr       <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= win_data;
            out_sel   <= grant_idx;
            if (mode == MODE_RR) begin
                ptr <= (grant_idx == SEL_W'(NUM_SRC - 1)) ? '0 : grant_idx + SEL_W'(1);
            end
        end else if (out_ready) begin
            // Drained with nothing to refill: data and select keep their last values.
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rr_arb_mux.sv
// Scoreboard bench for rr_arb_mux: a reference model predicts grants and
// queues each expected word, compared when the consumer takes it.
module tb_rr_arb_mux;
    import arch_pkg::*;

    localparam int WIDTH   = 32;
    localparam int NUM_SRC = 5;
    localparam int SEL_W   = clog2_min1(NUM_SRC);

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic                     mode = MODE_RR;
    logic [NUM_SRC-1:0]       src_valid = '0;
    logic [NUM_SRC*WIDTH-1:0] src_data;
    logic [NUM_SRC-1:0]       src_ready;
    logic                     out_valid;
    logic [WIDTH-1:0]         out_data;
    logic [SEL_W-1:0]         out_sel;
    logic                     out_ready = 1'b0;

    logic [WIDTH-1:0] sd [NUM_SRC];

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [SEL_W-1:0] sel;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    logic m_valid = 1'b0;
    int   m_ptr = 0;

    always #5 clk = ~clk;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_flat
        assign src_data[i*WIDTH +: WIDTH] = sd[i];
    end

    rr_arb_mux #(
        .WIDTH   (WIDTH),
        .NUM_SRC (NUM_SRC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .src_valid (src_valid),
        .src_data  (src_data),
        .src_ready (src_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int exp_grant(input logic [NUM_SRC-1:0] v, input logic md, input int ptr);
        if (md == MODE_FIXED) begin
            for (int i = 0; i < NUM_SRC; i++) if (v[i]) return i;
            return -1;
        end
        for (int k = 0; k < NUM_SRC; k++) begin
            if (v[(ptr + k) % NUM_SRC]) return (ptr + k) % NUM_SRC;
        end
        return -1;
    endfunction

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic step(input logic [NUM_SRC-1:0] v, input logic rdy, input logic md);
        int                 g;
        logic               ld;
        logic [NUM_SRC-1:0] er;
        exp_t               e;
        src_valid = v;
        out_ready = rdy;
        mode      = md;
        #1;
        g  = exp_grant(v, md, m_ptr);
        ld = !m_valid || rdy;
        er = (g >= 0 && ld) ? (NUM_SRC'(1) << g) : '0;
        check("src_ready", 64'(src_ready), 64'(er));
        check("out_valid", 64'(out_valid), 64'(m_valid));
        if (m_valid && rdy && sb.size() > 0) begin
            e = sb.pop_front();
            check("out_data", 64'(out_data), 64'(e.data));
            check("out_sel", 64'(out_sel), 64'(e.sel));
        end
        @(posedge clk);
        if (g >= 0 && ld) begin
            e.data = sd[g];
            e.sel  = SEL_W'(g);
            sb.push_back(e);
            m_valid = 1'b1;
            if (md == MODE_RR) m_ptr = (g + 1) % NUM_SRC;
        end else if (rdy) begin
            m_valid = 1'b0;
        end
        @(negedge clk);
    endtask

    initial begin
        int seq [6] = '{0, 1, 2, 3, 4, 0};
        for (int i = 0; i < NUM_SRC; i++) sd[i] = WIDTH'(32'h10 + i);

        #1;
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_data", 64'(out_data), 64'd0);
        check("rst_sel", 64'(out_sel), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Round-robin fairness with every source requesting
        for (int k = 0; k < 6; k++) begin
            step(5'h1F, 1'b1, MODE_RR);
            check("rr_seq", 64'(out_sel), 64'(seq[k]));
            check("rr_data", 64'(out_data), 64'(32'h10 + seq[k]));
        end

        // Fixed priority: source 1 always beats source 3
        for (int k = 0; k < 4; k++) begin
            step(5'b01010, 1'b1, MODE_FIXED);
            check("fixed_data", 64'(out_data), 64'h11);
        end
        // Pointer was left at 1 by round-robin and not moved by fixed mode
        step(5'b00011, 1'b1, MODE_RR);
        check("ptr_kept", 64'(out_sel), 64'd1);

        // Back-pressure: one transfer, then hold for three stalled cycles
        step('0, 1'b1, MODE_RR);
        step(5'b00100, 1'b0, MODE_RR);
        for (int k = 0; k < 3; k++) begin
            step(5'b00100, 1'b0, MODE_RR);
            check("stall_data", 64'(out_data), 64'h12);
            check("stall_valid", 64'(out_valid), 64'd1);
        end
        step(5'b00100, 1'b1, MODE_RR);
        check("no_bubble", 64'(out_valid), 64'd1);

        // Wrap with sparse requests
        step('0, 1'b1, MODE_RR);
        step(5'b01000, 1'b1, MODE_RR);
        check("wrap_sel3", 64'(out_sel), 64'd3);
        step(5'b00001, 1'b1, MODE_RR);
        check("wrap_sel0", 64'(out_sel), 64'd0);
        step(5'b10001, 1'b1, MODE_RR);
        check("wrap_sel4", 64'(out_sel), 64'd4);

        // Drain: valid falls, data and select retained
        step('0, 1'b1, MODE_RR);
        check("drain_valid", 64'(out_valid), 64'd0);
        check("drain_data", 64'(out_data), 64'h14);
        check("drain_sel", 64'(out_sel), 64'd4);

        // Asynchronous reset while a word is held
        sd[2] = 32'hDEAD_BEEF;
        step(5'b00100, 1'b0, MODE_RR);
        check("pre_rst_data", 64'(out_data), 64'hDEAD_BEEF);
        rst       = 1'b1;
        src_valid = '0;
        #1;
        check("arst_valid", 64'(out_valid), 64'd0);
        check("arst_data", 64'(out_data), 64'd0);
        check("arst_sel", 64'(out_sel), 64'd0);
        sb.delete();
        m_valid = 1'b0;
        m_ptr   = 0;
        @(negedge clk);
        rst   = 1'b0;
        sd[2] = 32'h12;
        step(5'h1F, 1'b1, MODE_RR);
        check("arst_ptr", 64'(out_sel), 64'd0);

        // Random traffic: requests, back-pressure, data and occasional mode flips
        for (int k = 0; k < 300; k++) begin
            for (int i = 0; i < NUM_SRC; i++) sd[i] = $urandom;
            step(NUM_SRC'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0);
        end

        for (int k = 0; k < 10 && m_valid; k++) step('0, 1'b1, MODE_RR);
        check("sb_empty", 64'(sb.size()), 64'd0);
        check("end_valid", 64'(out_valid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
